// File: rtl/memctrl_arb.sv
// memctrl_arb: arbitrates NUM_CH requestors onto a single byte-wide synchronous
// RAM bus and serialises variable-length loads/stores of up to DATA_W/8 bytes.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   rdy                 global enable; low freezes the block and blocks writes
//   io_buffer_full      IO sink busy; stalls writes into the IO region
//   mem_din             RAM read byte, valid the cycle after its address
//   mem_wr              1 = RAM write this cycle (combinational)
//   mem_a, mem_dout     RAM byte address and write byte (hold when idle)
//   req_valid/we/sext   per-channel request, direction, sign-extend flag
//   req_len/addr/wdata  per-channel byte count, start address, store data
//   grant               one-hot channel currently being served
//   done                one-cycle completion pulse per channel
//   rdata               load result, valid while done is high
module memctrl_arb #(
  parameter int unsigned       NUM_CH     = 2,
  parameter int unsigned       ADDR_W     = 32,
  parameter int unsigned       DATA_W     = 32,
  parameter int unsigned       LEN_W      = 3,
  parameter int unsigned       FIXED_PRIO = 0,
  parameter logic [ADDR_W-1:0] IO_BASE    = ADDR_W'(32'h30000)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rdy,
  input  logic                       io_buffer_full,
  input  logic [7:0]                 mem_din,
  output logic                       mem_wr,
  output logic [ADDR_W-1:0]          mem_a,
  output logic [7:0]                 mem_dout,
  input  logic [NUM_CH-1:0]          req_valid,
  input  logic [NUM_CH-1:0]          req_we,
  input  logic [NUM_CH-1:0]          req_sext,
  input  logic [NUM_CH*LEN_W-1:0]    req_len,
  input  logic [NUM_CH*ADDR_W-1:0]   req_addr,
  input  logic [NUM_CH*DATA_W-1:0]   req_wdata,
  output logic [NUM_CH-1:0]          grant,
  output logic [NUM_CH-1:0]          done,
  output logic [DATA_W-1:0]          rdata
);

  localparam int unsigned MAXB  = DATA_W / 8;
  localparam int unsigned PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [LEN_W-1:0]    cnt_q, cnt_d;
  logic                sext_q, sext_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rbuf_q, rbuf_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [NUM_CH-1:0]   grant_q, grant_d;
  logic [NUM_CH-1:0]   done_q, done_d;
  logic [ADDR_W-1:0]   a_hold_q;
  logic [7:0]          dout_hold_q;
  logic [7:0]          din_hold_q;
  logic                din_hold_vld_q;

  logic [NUM_CH-1:0]   eligible;
  logic                found;
  logic [PTR_W-1:0]    win;
  logic [PTR_W-1:0]    cand;
  logic [LEN_W-1:0]    w_len;
  logic                w_len_ok;
  logic                stall;
  logic                bus_act;
  logic [ADDR_W-1:0]   cur_a;
  logic [7:0]          cur_dout;
  logic [7:0]          din_eff;
  logic [DATA_W-1:0]   rfull;
  logic [DATA_W-1:0]   rext;
  logic                sign;

  // Channel index base+off, wrapped into 0..NUM_CH-1 (off < NUM_CH).
  function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W-1:0] base,
                                                input int unsigned off);
    int unsigned j;
    j = 32'(base) + off;
    if (j >= NUM_CH) j = j - NUM_CH;
    return PTR_W'(j);
  endfunction

  // Arbitration: done masks a request whose completion is still being reported.
  always_comb begin
    eligible = req_valid & ~done_q;
    found    = 1'b0;
    win      = '0;
    cand     = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      cand = (FIXED_PRIO != 0) ? PTR_W'(i) : wrap_idx(rr_ptr_q, i);
      if (!found && eligible[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  assign w_len    = req_len[32'(win)*LEN_W +: LEN_W];
  assign w_len_ok = (w_len != '0) && (32'(w_len) <= MAXB);

  // Bus-side view of the current transfer.
  assign stall    = (state_q == WRITE) && (addr_q >= IO_BASE) && io_buffer_full;
  assign bus_act  = ((state_q == READ) && (cnt_q < len_q)) || (state_q == WRITE);
  assign cur_a    = addr_q + ADDR_W'(cnt_q);
  assign cur_dout = wdata_q[8*32'(cnt_q) +: 8];

  // A byte returned just before a freeze is replaced by the RAM during the
  // frozen cycles, so the first frozen edge parks it for use on resume.
  assign din_eff  = din_hold_vld_q ? din_hold_q : mem_din;

  assign mem_a    = bus_act ? cur_a : a_hold_q;
  assign mem_dout = (state_q == WRITE) ? cur_dout : dout_hold_q;
  assign mem_wr   = !rst && rdy && (state_q == WRITE) && !stall;

  assign grant    = grant_q;
  assign done     = done_q;
  assign rdata    = rdata_q;

  // Read assembly: merge the arriving byte, then extend above 8*len.
  always_comb begin
    rfull = rbuf_q;
    if (cnt_q != '0) rfull[8*(32'(cnt_q)-1) +: 8] = din_eff;
    sign = 1'b0;
    for (int unsigned b = 0; b < MAXB; b++) begin
      if (sext_q && (32'(len_q) == b + 1)) sign = rfull[8*b+7];
    end
    rext = rfull;
    for (int unsigned b = 0; b < MAXB; b++) begin
      if (b >= 32'(len_q)) rext[8*b +: 8] = {8{sign}};
    end
  end

  // Next-state logic. Invalid lengths are latched as 0 and run through READ,
  // which finishes at cnt=0 with no bus traffic and a zero result.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    addr_d   = addr_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    sext_d   = sext_q;
    wdata_d  = wdata_q;
    rbuf_d   = rbuf_q;
    rdata_d  = rdata_q;
    grant_d  = grant_q;
    done_d   = '0;
    case (state_q)
      IDLE: begin
        if (found) begin
          addr_d   = req_addr[32'(win)*ADDR_W +: ADDR_W];
          len_d    = w_len_ok ? w_len : '0;
          sext_d   = req_sext[win];
          wdata_d  = req_wdata[32'(win)*DATA_W +: DATA_W];
          cnt_d    = '0;
          rbuf_d   = '0;
          grant_d  = NUM_CH'(1) << win;
          rr_ptr_d = wrap_idx(win, 1);
          state_d  = (req_we[win] && w_len_ok) ? WRITE : READ;
        end
      end
      READ: begin
        rbuf_d = rfull;
        if (cnt_q == len_q) begin
          rdata_d = rext;
          done_d  = grant_q;
          grant_d = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + LEN_W'(1);
        end
      end
      WRITE: begin
        if (!stall) begin
          if (cnt_q == len_q - LEN_W'(1)) begin
            done_d  = grant_q;
            grant_d = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + LEN_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; rdy low freezes everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      addr_q      <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      sext_q      <= 1'b0;
      wdata_q     <= '0;
      rbuf_q      <= '0;
      rdata_q     <= '0;
      grant_q     <= '0;
      done_q      <= '0;
      a_hold_q    <= '0;
      dout_hold_q <= '0;
    end else if (rdy) begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      sext_q   <= sext_d;
      wdata_q  <= wdata_d;
      rbuf_q   <= rbuf_d;
      rdata_q  <= rdata_d;
      grant_q  <= grant_d;
      done_q   <= done_d;
      if (bus_act)          a_hold_q    <= cur_a;
      if (state_q == WRITE) dout_hold_q <= cur_dout;
    end
  end

  // Read-data park register for freezes.
  always_ff @(posedge clk) begin
    if (rst) begin
      din_hold_q     <= '0;
      din_hold_vld_q <= 1'b0;
    end else if (!rdy) begin
      if (!din_hold_vld_q) begin
        din_hold_q     <= mem_din;
        din_hold_vld_q <= 1'b1;
      end
    end else begin
      din_hold_vld_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_memctrl_arb.sv
// tb_memctrl_arb: directed bench for memctrl_arb with a byte RAM model,
// a write log, and a second instance in fixed-priority mode with 3 channels.
module tb_memctrl_arb;

  localparam int unsigned NUM_CH = 2;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned LEN_W  = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                      rst;
  logic                      rdy;
  logic                      io_buffer_full;
  logic [7:0]                mem_din;
  logic                      mem_wr;
  logic [ADDR_W-1:0]         mem_a;
  logic [7:0]                mem_dout;
  logic [NUM_CH-1:0]         req_valid;
  logic [NUM_CH-1:0]         req_we;
  logic [NUM_CH-1:0]         req_sext;
  logic [NUM_CH*LEN_W-1:0]   req_len;
  logic [NUM_CH*ADDR_W-1:0]  req_addr;
  logic [NUM_CH*DATA_W-1:0]  req_wdata;
  logic [NUM_CH-1:0]         grant;
  logic [NUM_CH-1:0]         done;
  logic [DATA_W-1:0]         rdata;

  logic [2:0]   fp_valid;
  logic [2:0]   fp_we;
  logic [2:0]   fp_sext;
  logic [8:0]   fp_len;
  logic [95:0]  fp_addr;
  logic [95:0]  fp_wdata;
  logic [7:0]   fp_din;
  logic         fp_mem_wr;
  logic [31:0]  fp_mem_a;
  logic [7:0]   fp_mem_dout;
  logic [2:0]   fp_grant;
  logic [2:0]   fp_done;
  logic [31:0]  fp_rdata;

  memctrl_arb #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W),
                .FIXED_PRIO(0)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .io_buffer_full(io_buffer_full),
    .mem_din(mem_din), .mem_wr(mem_wr), .mem_a(mem_a), .mem_dout(mem_dout),
    .req_valid(req_valid), .req_we(req_we), .req_sext(req_sext),
    .req_len(req_len), .req_addr(req_addr), .req_wdata(req_wdata),
    .grant(grant), .done(done), .rdata(rdata)
  );

  memctrl_arb #(.NUM_CH(3), .ADDR_W(32), .DATA_W(32), .LEN_W(3),
                .FIXED_PRIO(1)) dut_fp (
    .clk(clk), .rst(rst), .rdy(rdy), .io_buffer_full(1'b0),
    .mem_din(fp_din), .mem_wr(fp_mem_wr), .mem_a(fp_mem_a), .mem_dout(fp_mem_dout),
    .req_valid(fp_valid), .req_we(fp_we), .req_sext(fp_sext),
    .req_len(fp_len), .req_addr(fp_addr), .req_wdata(fp_wdata),
    .grant(fp_grant), .done(fp_done), .rdata(fp_rdata)
  );

  // RAM model: data for an address appears the cycle after it is presented.
  logic [7:0]  ram [logic [31:0]];
  logic [39:0] wlog [$];

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : 8'h00;
  endfunction

  always @(posedge clk) begin
    mem_din <= ram_rd(mem_a);
    if (mem_wr) wlog.push_back({mem_a, mem_dout});
  end

  int vectors    = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_req(input int ch, input logic we, input logic sx, input int len,
                         input logic [31:0] a, input logic [31:0] wd);
    req_we[ch]                       = we;
    req_sext[ch]                     = sx;
    req_len[ch*LEN_W +: LEN_W]       = LEN_W'(len);
    req_addr[ch*ADDR_W +: ADDR_W]    = a;
    req_wdata[ch*DATA_W +: DATA_W]   = wd;
    req_valid[ch]                    = 1'b1;
  endtask

  task automatic wait_done(input int ch, input int limit, output int n);
    n = 0;
    while (n < limit) begin
      tick();
      n++;
      if (done[ch]) break;
    end
  endtask

  // Full read on one channel: latency counted from request to done.
  task automatic do_read(input string tag, input int ch, input logic sx, input int len,
                         input logic [31:0] a, input logic [31:0] exp, input int exp_lat);
    int n;
    set_req(ch, 1'b0, sx, len, a, 32'h0);
    wait_done(ch, 40, n);
    chk({tag, "_lat"}, 64'(n), 64'(exp_lat));
    chk({tag, "_rdata"}, 64'(rdata), 64'(exp));
    req_valid[ch] = 1'b0;
    tick();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [1:0]  last;
    logic [1:0]  gseq [$];
    logic [1:0]  rr_exp [4];
    logic [39:0] wexp [4];

    rst = 1'b1; rdy = 1'b1; io_buffer_full = 1'b0;
    req_valid = '0; req_we = '0; req_sext = '0;
    req_len = '0; req_addr = '0; req_wdata = '0;
    fp_valid = '0; fp_we = '0; fp_sext = '0; fp_len = '0;
    fp_addr = '0; fp_wdata = '0; fp_din = '0;
    ram[32'h100] = 8'h11; ram[32'h101] = 8'h22; ram[32'h102] = 8'h33; ram[32'h103] = 8'h44;
    ram[32'h200] = 8'h80;
    ram[32'h300] = 8'h01; ram[32'h301] = 8'h80;

    // Reset state
    tick(2);
    chk("rst_grant", 64'(grant), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_rdata", 64'(rdata), 64'd0);
    chk("rst_mem_a", 64'(mem_a), 64'd0);
    chk("rst_mem_dout", 64'(mem_dout), 64'd0);
    chk("rst_mem_wr", 64'(mem_wr), 64'd0);
    chk("rst_fp_grant", 64'(fp_grant), 64'd0);
    rst = 1'b0;
    tick();

    // Round-robin with both channels held: grants alternate from ch0
    rr_exp = '{2'b01, 2'b10, 2'b01, 2'b10};
    set_req(0, 1'b0, 1'b0, 1, 32'h200, 32'h0);
    set_req(1, 1'b0, 1'b0, 1, 32'h300, 32'h0);
    last = 2'b00;
    for (int t = 0; t < 40 && gseq.size() < 4; t++) begin
      tick();
      if (grant != 2'b00 && last == 2'b00) gseq.push_back(grant);
      last = grant;
    end
    for (int i = 0; i < 4; i++)
      chk($sformatf("rr_grant%0d", i), 64'((gseq.size() > i) ? gseq[i] : 2'b00), 64'(rr_exp[i]));
    req_valid = '0;
    tick(8);

    // 4-byte read: consecutive addresses, done 6 cycles after request
    set_req(0, 1'b0, 1'b0, 4, 32'h100, 32'h0);
    tick();
    chk("rd4_grant", 64'(grant), 64'd1);
    chk("rd4_a0", 64'(mem_a), 64'h100);
    chk("rd4_wr", 64'(mem_wr), 64'd0);
    tick(); chk("rd4_a1", 64'(mem_a), 64'h101);
    tick(); chk("rd4_a2", 64'(mem_a), 64'h102);
    tick(); chk("rd4_a3", 64'(mem_a), 64'h103);
    tick(); chk("rd4_notdone", 64'(done), 64'd0);
    tick();
    chk("rd4_done", 64'(done), 64'd1);
    chk("rd4_rdata", 64'(rdata), 64'h44332211);
    chk("rd4_grant_clr", 64'(grant), 64'd0);
    req_valid[0] = 1'b0;
    tick();

    // Sign / zero extension
    do_read("sx1", 0, 1'b1, 1, 32'h200, 32'hFFFFFF80, 3);
    do_read("sx2", 0, 1'b1, 2, 32'h300, 32'hFFFF8001, 4);
    do_read("zx1", 0, 1'b0, 1, 32'h200, 32'h00000080, 3);
    do_read("zx2", 1, 1'b0, 2, 32'h300, 32'h00008001, 4);

    // rdy low for 2 cycles at cnt=2 of a 4-byte read
    set_req(0, 1'b0, 1'b0, 4, 32'h100, 32'h0);
    tick(3);
    rdy = 1'b0;
    #1 chk("frz_wr0", 64'(mem_wr), 64'd0);
    tick();
    chk("frz_grant", 64'(grant), 64'd1);
    chk("frz_wr1", 64'(mem_wr), 64'd0);
    tick();
    rdy = 1'b1;
    wait_done(0, 20, n);
    chk("frz_lat", 64'(5 + n), 64'd8);
    chk("frz_rdata", 64'(rdata), 64'h44332211);
    req_valid[0] = 1'b0;
    tick();

    // IO write stalled 3 cycles at cnt=1
    wlog.delete();
    set_req(0, 1'b1, 1'b0, 4, 32'h30000, 32'hDEADBEEF);
    tick();
    chk("io_wr_c0", 64'(mem_wr), 64'd1);
    chk("io_a_c0", 64'(mem_a), 64'h30000);
    chk("io_dout_c0", 64'(mem_dout), 64'hEF);
    tick();
    io_buffer_full = 1'b1;
    #1 chk("io_stall0", 64'(mem_wr), 64'd0);
    tick(); chk("io_stall1", 64'(mem_wr), 64'd0);
    tick(); chk("io_stall2", 64'(mem_wr), 64'd0);
    tick();
    io_buffer_full = 1'b0;
    #1 chk("io_wr_c1", 64'(mem_wr), 64'd1);
    chk("io_a_c1", 64'(mem_a), 64'h30001);
    chk("io_dout_c1", 64'(mem_dout), 64'hBE);
    wait_done(0, 20, n);
    chk("io_lat", 64'(5 + n), 64'd8);
    req_valid[0] = 1'b0;
    tick();
    wexp = '{{32'h30000, 8'hEF}, {32'h30001, 8'hBE}, {32'h30002, 8'hAD}, {32'h30003, 8'hDE}};
    chk("io_nwrites", 64'(wlog.size()), 64'd4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("io_byte%0d", i), 64'((wlog.size() > i) ? wlog[i] : 40'h0), 64'(wexp[i]));

    // Fixed priority, 3 channels: ch1 beats ch2, ch2 served after ch1 drops
    fp_len   = {3'd1, 3'd1, 3'd1};
    fp_valid = 3'b110;
    tick();
    chk("fp_first", 64'(fp_grant), 64'b010);
    n = 0;
    while (n < 20 && !fp_done[1]) begin tick(); n++; end
    chk("fp_done1", 64'(fp_done), 64'b010);
    fp_valid[1] = 1'b0;
    tick();
    chk("fp_second", 64'(fp_grant), 64'b100);
    n = 0;
    while (n < 20 && !fp_done[2]) begin tick(); n++; end
    chk("fp_done2", 64'(fp_done), 64'b100);
    fp_valid = '0;
    tick();

    // Reset at cnt=2 of a 4-byte write
    wlog.delete();
    set_req(0, 1'b1, 1'b0, 4, 32'h400, 32'h11223344);
    tick(3);
    rst = 1'b1;
    req_valid = '0;
    #1 chk("rstw_wr", 64'(mem_wr), 64'd0);
    tick();
    chk("rstw_grant", 64'(grant), 64'd0);
    chk("rstw_done", 64'(done), 64'd0);
    chk("rstw_mem_a", 64'(mem_a), 64'd0);
    chk("rstw_nwrites", 64'(wlog.size()), 64'd2);
    chk("rstw_byte1", 64'((wlog.size() > 1) ? wlog[1] : 40'h0), 64'({32'h401, 8'h33}));
    rst = 1'b0;
    wlog.delete();

    // After reset rr_ptr=0 so ch0 wins; ch0 is a len=0 write
    set_req(0, 1'b1, 1'b0, 0, 32'h500, 32'hCAFEF00D);
    set_req(1, 1'b0, 1'b1, 1, 32'h200, 32'h0);
    tick();
    chk("len0_grant", 64'(grant), 64'd1);
    tick();
    chk("len0_done", 64'(done), 64'd1);
    chk("len0_rdata", 64'(rdata), 64'd0);
    req_valid[0] = 1'b0;
    tick();
    chk("len0_next_grant", 64'(grant), 64'd2);
    wait_done(1, 20, n);
    chk("len0_ch1_lat", 64'(n), 64'd2);
    chk("len0_ch1_rdata", 64'(rdata), 64'hFFFFFF80);
    req_valid[1] = 1'b0;
    tick();

    // len > MAXB: no traffic, result cleared
    set_req(0, 1'b0, 1'b1, 5, 32'h200, 32'h0);
    tick();
    chk("len5_grant", 64'(grant), 64'd1);
    tick();
    chk("len5_done", 64'(done), 64'd1);
    chk("len5_rdata", 64'(rdata), 64'd0);
    req_valid[0] = 1'b0;
    tick(2);
    chk("len_bad_nwrites", 64'(wlog.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
